// File: rtl/banked_node_cache.sv
// Multi-bank, multi-port node cache for the A* open/closed-set pipeline.
// Optional hit/miss counters are built when NODE_CACHE_STATS_EN is defined.
module banked_node_cache #(
   parameter int CACHE_SIZE = 1024,
   parameter int NUM_PORTS  = 8,
   parameter int NUM_BANKS  = 4,
   parameter int DATA_W     = 64
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NUM_PORTS-1:0]        rd_req_i,
   input  logic [NUM_PORTS*$clog2(CACHE_SIZE)-1:0] rd_addr_i,
   output logic [NUM_PORTS-1:0]        rd_gnt_o,
   output logic [NUM_PORTS-1:0]        rd_valid_o,
   output logic [NUM_PORTS-1:0]        rd_hit_o,
   output logic [NUM_PORTS*DATA_W-1:0] rd_data_o,
   input  logic                        wr_en_i,
   input  logic [$clog2(CACHE_SIZE)-1:0] wr_addr_i,
   input  logic [DATA_W-1:0]           wr_data_i,
   input  logic                        inv_en_i,
   input  logic [$clog2(CACHE_SIZE)-1:0] inv_addr_i,
   output logic                        wr_ready_o,
   input  logic                        flush_i,
   output logic                        busy_o
`ifdef NODE_CACHE_STATS_EN
   ,
   output logic [31:0]                 hit_cnt_o,
   output logic [31:0]                 miss_cnt_o
`endif
);
   localparam int AW   = $clog2(CACHE_SIZE);
   localparam int BW   = $clog2(NUM_BANKS);
   localparam int ROWS = CACHE_SIZE / NUM_BANKS;
   localparam int RW   = $clog2(ROWS);
   localparam int PW   = $clog2(NUM_PORTS);

   typedef enum logic [1:0] {INIT, READY, FLUSH} state_e;

   state_e                  state_q;
   logic [RW-1:0]           row_q;
   logic                    busy_q;

   logic [DATA_W-1:0]       mem_q [CACHE_SIZE];
   logic [CACHE_SIZE-1:0]   vld_q;

   logic [PW-1:0]           ptr_q [NUM_BANKS];
   logic [PW-1:0]           ptr_d [NUM_BANKS];
   logic [NUM_PORTS-1:0]    gnt;
   logic                    found;
   int                      cand;

   logic [AW-1:0]           paddr     [NUM_PORTS];
   logic                    resp_hit  [NUM_PORTS];
   logic [DATA_W-1:0]       resp_data [NUM_PORTS];

   logic [NUM_PORTS-1:0]        rd_valid_q;
   logic [NUM_PORTS-1:0]        rd_hit_q;
   logic [NUM_PORTS*DATA_W-1:0] rd_data_q;

   logic wr_acc;
   logic inv_acc;

   assign wr_acc     = wr_en_i  & ~busy_q;
   assign inv_acc    = inv_en_i & ~busy_q;
   assign busy_o     = busy_q;
   assign wr_ready_o = ~busy_q;
   assign rd_gnt_o   = gnt;
   assign rd_valid_o = rd_valid_q;
   assign rd_hit_o   = rd_hit_q;
   assign rd_data_o  = rd_data_q;

   // Per-bank round-robin: scan ports starting at the bank pointer, first requester wins.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      cand  = 0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         ptr_d[b] = ptr_q[b];
         found    = 1'b0;
         for (int k = 0; k < NUM_PORTS; k++) begin
            cand = (int'(ptr_q[b]) + k) % NUM_PORTS;
            if (!found && !busy_q && rd_req_i[cand] &&
                rd_addr_i[cand*AW +: BW] == BW'(b)) begin
               found     = 1'b1;
               gnt[cand] = 1'b1;
               ptr_d[b]  = PW'((cand + 1) % NUM_PORTS);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int b = 0; b < NUM_BANKS; b++) ptr_q[b] <= '0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) ptr_q[b] <= ptr_d[b];
      end
   end

   // Lookup with forwarding: a same-cycle write beats a same-cycle invalidate.
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         paddr[p]     = rd_addr_i[p*AW +: AW];
         resp_hit[p]  = vld_q[paddr[p]];
         resp_data[p] = vld_q[paddr[p]] ? mem_q[paddr[p]] : '0;
         if (inv_acc && inv_addr_i == paddr[p]) begin
            resp_hit[p]  = 1'b0;
            resp_data[p] = '0;
         end
         if (wr_acc && wr_addr_i == paddr[p]) begin
            resp_hit[p]  = 1'b1;
            resp_data[p] = wr_data_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_valid_q <= '0;
         rd_hit_q   <= '0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= gnt;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p]) begin
               rd_hit_q[p]                   <= resp_hit[p];
               rd_data_q[p*DATA_W +: DATA_W] <= resp_data[p];
            end
         end
      end
   end

   // Sweep clears one row across all banks per cycle; address = {row, bank}.
   always_ff @(posedge clk_i) begin
      if (busy_q) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            mem_q[{row_q, BW'(b)}] <= '0;
            vld_q[{row_q, BW'(b)}] <= 1'b0;
         end
      end else begin
         if (inv_acc) vld_q[inv_addr_i] <= 1'b0;
         if (wr_acc) begin
            mem_q[wr_addr_i] <= wr_data_i;
            vld_q[wr_addr_i] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= INIT;
         row_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            INIT, FLUSH: begin
               row_q <= row_q + RW'(1);
               if (row_q == RW'(ROWS - 1)) begin
                  state_q <= READY;
                  busy_q  <= 1'b0;
               end
            end
            READY: begin
               if (flush_i) begin
                  state_q <= FLUSH;
                  busy_q  <= 1'b1;
                  row_q   <= '0;
               end
            end
            default: begin
               state_q <= INIT;
               busy_q  <= 1'b1;
               row_q   <= '0;
            end
         endcase
      end
   end

`ifdef NODE_CACHE_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;
   logic [PW:0] n_hit;
   logic [PW:0] n_miss;

   function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [PW:0] inc);
      logic [32:0] sum;
      sum = {1'b0, acc} + {{(32-PW){1'b0}}, inc};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

   always_comb begin
      n_hit  = '0;
      n_miss = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         n_hit  = n_hit  + {{PW{1'b0}}, rd_valid_q[p] &  rd_hit_q[p]};
         n_miss = n_miss + {{PW{1'b0}}, rd_valid_q[p] & ~rd_hit_q[p]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (state_q == READY && flush_i) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= sat_add(hit_cnt_q, n_hit);
         miss_cnt_q <= sat_add(miss_cnt_q, n_miss);
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: doc/banked_node_cache.md
Name: banked_node_cache

Overview:
- Successor to the single-array node store: a multi-bank, multi-port node cache for the A* open/closed-set pipeline.
- Adds per-entry valid bits with hit/miss reporting, per-bank round-robin read arbitration with a request/grant handshake, and write-to-read forwarding.
- Adds a sweep FSM that clears all entries after reset or on a flush request.
- Sits between the expansion/neighbour-generation stage (readers) and the priority-queue update stage (single writer).

Parameters:
- CACHE_SIZE, 1024: total entries; power of two, divisible by NUM_BANKS.
- NUM_PORTS, 8: read ports.
- NUM_BANKS, 4: banks, power of two; bank = addr[$clog2(NUM_BANKS)-1:0], row = remaining upper bits.
- DATA_W, 64: node payload width.
- Derived: AW=$clog2(CACHE_SIZE), ROWS=CACHE_SIZE/NUM_BANKS.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_req  in  NUM_PORTS  per-port read request.
- rd_addr  in  NUM_PORTS*AW  per-port address, port i at [i*AW +: AW].
- rd_gnt  out  NUM_PORTS  combinational grant; request accepted this cycle when rd_req&rd_gnt.
- rd_valid  out  NUM_PORTS  response valid, exactly 1 cycle after grant.
- rd_hit  out  NUM_PORTS  entry valid at read time; qualified by rd_valid.
- rd_data  out  NUM_PORTS*DATA_W  response data; zero on miss.
- wr_en  in  1  write request.
- wr_addr  in  AW  write address.
- wr_data  in  DATA_W  write data; sets entry valid.
- inv_en  in  1  invalidate request.
- inv_addr  in  AW  address to invalidate.
- wr_ready  out  1  high when writes/invalidates are accepted (=!busy).
- flush  in  1  single-cycle pulse; starts clear sweep.
- busy  out  1  high while a sweep is in progress.

Behaviour:
- Reset (rst=0): FSM->INIT, sweep row counter=0, rd_gnt=0, rd_valid=0, rd_hit=0, rd_data=0, busy=1, wr_ready=0. Reset asserted mid-operation aborts everything and restarts INIT at row 0.
- FSM states: INIT, READY, FLUSH.
  - INIT/FLUSH: each cycle clear valid and zero data for row r in all banks; r increments. On the clear of row ROWS-1, next state is READY. Sweep length is ROWS cycles (256 at defaults).
  - READY: flush=1 moves to FLUSH with r=0.
  - flush during INIT/FLUSH is ignored (no restart).
- busy=1 in INIT/FLUSH. While busy: rd_gnt=0, wr_ready=0, and wr_en/inv_en are dropped.
- Read arbitration:
  - Each bank grants at most one port per cycle among ports requesting that bank.
  - Round-robin pointer per bank; after a grant to port p, pointer = (p+1) mod NUM_PORTS. Pointer reset = 0.
  - Non-granted ports keep rd_req/rd_addr stable until granted.
  - Different banks grant in parallel; up to min(NUM_PORTS,NUM_BANKS) grants per cycle.
- Read latency 1: for a grant at cycle N, rd_valid/rd_hit/rd_data are valid at N+1 for one cycle. Otherwise rd_valid=0 and rd_data holds its previous value.
- Write: when wr_en & wr_ready, the entry is written and its valid bit set at the clock edge. Writes never conflict with reads (separate write port per bank). At most one write per cycle.
- Invalidate: when inv_en & wr_ready, the valid bit is cleared; data is untouched.
- Same-cycle write and invalidate to the same address: write wins (entry valid). To different addresses: both take effect.
- Forwarding: a read granted in the same cycle as an accepted write to the same address returns wr_data with rd_hit=1. A same-cycle invalidate to the same address returns rd_hit=0, rd_data=0 (unless overridden by a same-address write).
- Miss: rd_hit=0, rd_data=0.

Optional Feature:
- Macro: NODE_CACHE_STATS_EN.
- Defined: adds outputs hit_cnt (32) and miss_cnt (32). Counters add the number of rd_valid&rd_hit and rd_valid&!rd_hit bits each cycle, saturate at 2^32-1, clear on reset and at FLUSH entry.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Release rst at cycle 0 -> busy=1 for exactly 256 cycles, wr_ready=0, rd_gnt=0 throughout; busy=0 on cycle 256; every subsequent read returns rd_hit=0, rd_data=0.
- Write addr 0x005 data 0xDEAD_BEEF, then port 3 reads 0x005 -> rd_gnt[3]=1, next cycle rd_valid[3]=1, rd_hit[3]=1, rd_data[3]=0xDEAD_BEEF.
- Ports 0,1,2 all read bank-1 addresses 0x001, 0x005, 0x009 continuously -> grants in order 0,1,2 on consecutive cycles; port 4 reading 0x002 (bank 2) is granted in the first cycle in parallel.
- Same cycle: wr_en addr 0x010 data 0x1234 and port 0 reads 0x010 -> next cycle rd_hit[0]=1, rd_data[0]=0x1234. Then inv_en 0x010 -> next read gives rd_hit=0, rd_data=0.
- Write 0x3FF, pulse flush, pulse flush again 10 cycles later -> busy=1 for 256 cycles from the first pulse only; afterwards a read of 0x3FF misses.
- Assert rst at cycle 100 of INIT -> outputs zero immediately; after release, busy lasts a full 256 cycles. With NODE_CACHE_STATS_EN: 3 hits and 2 misses give hit_cnt=3, miss_cnt=2.
